// File: rtl/datapath_pkg.sv
// Shared widths and ALU operation codes for the 16-bit RISC datapath.
package datapath_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned MEM_AW = 3;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_INV = 4'b0010;
    localparam logic [3:0] ALU_SHL = 4'b0011;
    localparam logic [3:0] ALU_SHR = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0101;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU with zero flag; unknown op codes fall back to add.
module exec_alu
    import datapath_pkg::*;
#(
    parameter int unsigned DATA_W = datapath_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [3:0]        op_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    always_comb begin
        result_o = a_i + b_i;
        case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_INV: result_o = ~a_i;
            // Full-width shift amount: anything >= DATA_W shifts everything out.
            ALU_SHL: result_o = a_i << b_i;
            ALU_SHR: result_o = a_i >> b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
            default: result_o = a_i + b_i;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/datapath_exec_core.sv
// Execute/memory/write-back cluster: register file, ALU, data memory, write-back mux.
// Define GPR_R0_ZERO_EN to hard-wire register 0 to zero.
module datapath_exec_core
    import datapath_pkg::*;
#(
    parameter int unsigned DATA_W = datapath_pkg::DATA_W,
    parameter int unsigned REG_AW = datapath_pkg::REG_AW,
    parameter int unsigned MEM_AW = datapath_pkg::MEM_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] reg_read_addr_1,
    input  logic [REG_AW-1:0] reg_read_addr_2,
    input  logic [REG_AW-1:0] reg_write_dest,
    input  logic              reg_write_en,
    input  logic [3:0]        alu_control,
    input  logic              alu_src,
    input  logic [5:0]        imm,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic              mem_to_reg,
    output logic [DATA_W-1:0] reg_read_data_1,
    output logic [DATA_W-1:0] reg_read_data_2,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic [DATA_W-1:0] mem_read_data
);

    localparam int unsigned NUM_REGS  = 2 ** REG_AW;
    localparam int unsigned NUM_WORDS = 2 ** MEM_AW;

    logic [DATA_W-1:0] rf_q  [NUM_REGS];
    logic [DATA_W-1:0] rf_d  [NUM_REGS];
    logic [DATA_W-1:0] mem_q [NUM_WORDS];
    logic [DATA_W-1:0] mem_d [NUM_WORDS];

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] alu_b;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] wb_data;

`ifdef GPR_R0_ZERO_EN
    assign reg_read_data_1 = (reg_read_addr_1 == '0) ? '0 : rf_q[reg_read_addr_1];
    assign reg_read_data_2 = (reg_read_addr_2 == '0) ? '0 : rf_q[reg_read_addr_2];
`else
    assign reg_read_data_1 = rf_q[reg_read_addr_1];
    assign reg_read_data_2 = rf_q[reg_read_addr_2];
`endif

    assign imm_ext = {{(DATA_W-6){imm[5]}}, imm};
    assign alu_b   = alu_src ? imm_ext : reg_read_data_2;

    exec_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .a_i     (reg_read_data_1),
        .b_i     (alu_b),
        .op_i    (alu_control),
        .result_o(alu_result),
        .zero_o  (zero)
    );

    // Upper address bits are dropped, so addresses alias modulo NUM_WORDS.
    assign mem_addr      = alu_result[MEM_AW-1:0];
    assign mem_read_data = mem_read ? mem_q[mem_addr] : '0;
    assign wb_data       = mem_to_reg ? mem_read_data : alu_result;

    always_comb begin
        rf_d = rf_q;
        if (reg_write_en) begin
            rf_d[reg_write_dest] = wb_data;
        end
`ifdef GPR_R0_ZERO_EN
        rf_d[0] = '0;
`endif
    end

    always_comb begin
        mem_d = mem_q;
        if (mem_write) begin
            mem_d[mem_addr] = reg_read_data_2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rf_q  <= rf_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_datapath_exec_core.sv
// Directed self-checking bench for datapath_exec_core; honours GPR_R0_ZERO_EN.
module tb_datapath_exec_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  reg_read_addr_1;
    logic [2:0]  reg_read_addr_2;
    logic [2:0]  reg_write_dest;
    logic        reg_write_en;
    logic [3:0]  alu_control;
    logic        alu_src;
    logic [5:0]  imm;
    logic        mem_write;
    logic        mem_read;
    logic        mem_to_reg;
    logic [15:0] reg_read_data_1;
    logic [15:0] reg_read_data_2;
    logic [15:0] alu_result;
    logic        zero;
    logic [15:0] mem_read_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    datapath_exec_core dut (
        .clk            (clk),
        .reset          (reset),
        .reg_read_addr_1(reg_read_addr_1),
        .reg_read_addr_2(reg_read_addr_2),
        .reg_write_dest (reg_write_dest),
        .reg_write_en   (reg_write_en),
        .alu_control    (alu_control),
        .alu_src        (alu_src),
        .imm            (imm),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_to_reg     (mem_to_reg),
        .reg_read_data_1(reg_read_data_1),
        .reg_read_data_2(reg_read_data_2),
        .alu_result     (alu_result),
        .zero           (zero),
        .mem_read_data  (mem_read_data)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset           = 1'b0;
        reg_read_addr_1 = 3'd0;
        reg_read_addr_2 = 3'd0;
        reg_write_dest  = 3'd0;
        reg_write_en    = 1'b0;
        alu_control     = 4'b0000;
        alu_src         = 1'b0;
        imm             = 6'd0;
        mem_write       = 1'b0;
        mem_read        = 1'b0;
        mem_to_reg      = 1'b0;
    endtask

    // rd = r0 + sext(value) via ADD-immediate.
    task automatic load_imm(input logic [2:0] rd, input logic [5:0] value);
        idle();
        alu_src        = 1'b1;
        imm            = value;
        reg_write_dest = rd;
        reg_write_en   = 1'b1;
        step();
        idle();
    endtask

    task automatic read_reg(input string tag, input logic [2:0] ra, input logic [15:0] exp);
        idle();
        reg_read_addr_1 = ra;
        reg_read_addr_2 = ra;
        #1;
        check({tag, "_p1"}, reg_read_data_1, exp);
        check({tag, "_p2"}, reg_read_data_2, exp);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step();
        idle();

        for (int i = 0; i < 8; i++) begin
            read_reg($sformatf("rst_r%0d", i), 3'(i), 16'h0000);
            idle();
            alu_src  = 1'b1;
            imm      = 6'(i);
            mem_read = 1'b1;
            #1;
            check($sformatf("rst_mem%0d", i), mem_read_data, 16'h0000);
        end
        idle();
        #1;
        check("rst_alu", alu_result, 16'h0000);
        check("rst_zero", {15'd0, zero}, 16'h0001);

        load_imm(3'd1, 6'd5);
        load_imm(3'd2, 6'd3);
        read_reg("r1", 3'd1, 16'h0005);
        read_reg("r2", 3'd2, 16'h0003);

        idle();
        reg_read_addr_1 = 3'd1;
        reg_read_addr_2 = 3'd2;
        alu_control     = 4'b0001;
        #1;
        check("sub_r1r2", alu_result, 16'h0002);
        check("sub_r1r2_z", {15'd0, zero}, 16'h0000);
        reg_read_addr_1 = 3'd2;
        #1;
        check("sub_r2r2", alu_result, 16'h0000);
        check("sub_r2r2_z", {15'd0, zero}, 16'h0001);
        reg_read_addr_1 = 3'd2;
        reg_read_addr_2 = 3'd1;
        #1;
        check("sub_wrap", alu_result, 16'hFFFE);

        load_imm(3'd3, 6'b111111);
        read_reg("r3_sext", 3'd3, 16'hFFFF);

        idle();
        reg_read_addr_1 = 3'd1;
        reg_read_addr_2 = 3'd3;
        alu_control     = 4'b0111;
        #1;
        check("slt_1_lt_ffff", alu_result, 16'h0001);
        reg_read_addr_1 = 3'd3;
        reg_read_addr_2 = 3'd1;
        #1;
        check("slt_ffff_lt_5", alu_result, 16'h0000);

        load_imm(3'd6, 6'd1);
        idle();
        reg_read_addr_1 = 3'd6;
        alu_src         = 1'b1;
        alu_control     = 4'b0011;
        imm             = 6'd4;
        #1;
        check("shl_1_by_4", alu_result, 16'h0010);
        imm = 6'd16;
        #1;
        check("shl_1_by_16", alu_result, 16'h0000);
        imm            = 6'd15;
        reg_write_dest = 3'd7;
        reg_write_en   = 1'b1;
        step();
        read_reg("r7_8000", 3'd7, 16'h8000);

        idle();
        reg_read_addr_1 = 3'd7;
        alu_src         = 1'b1;
        alu_control     = 4'b0100;
        imm             = 6'd20;
        #1;
        check("shr_by_20", alu_result, 16'h0000);
        imm = 6'd15;
        #1;
        check("shr_by_15", alu_result, 16'h0001);
        alu_control = 4'b0010;
        #1;
        check("inv_8000", alu_result, 16'h7FFF);

        // Store r1 at 0x000A, which aliases word 2.
        idle();
        alu_src         = 1'b1;
        imm             = 6'd10;
        reg_read_addr_2 = 3'd1;
        mem_write       = 1'b1;
        step();
        idle();
        alu_src  = 1'b1;
        imm      = 6'd2;
        mem_read = 1'b1;
        #1;
        check("mem_alias_w2", mem_read_data, 16'h0005);
        imm            = 6'd10;
        mem_to_reg     = 1'b1;
        reg_write_dest = 3'd4;
        reg_write_en   = 1'b1;
        step();
        read_reg("load_r4", 3'd4, 16'h0005);

        idle();
        alu_src        = 1'b1;
        imm            = 6'd10;
        mem_to_reg     = 1'b1;
        reg_write_dest = 3'd4;
        reg_write_en   = 1'b1;
        step();
        read_reg("load_nord_r4", 3'd4, 16'h0000);

        // Store r2 and load into r5 at the same address in one cycle.
        idle();
        alu_src         = 1'b1;
        imm             = 6'd2;
        reg_read_addr_2 = 3'd2;
        mem_write       = 1'b1;
        mem_read        = 1'b1;
        mem_to_reg      = 1'b1;
        reg_write_dest  = 3'd5;
        reg_write_en    = 1'b1;
        step();
        read_reg("ldst_old_r5", 3'd5, 16'h0005);
        idle();
        alu_src  = 1'b1;
        imm      = 6'd2;
        mem_read = 1'b1;
        #1;
        check("ldst_new_mem", mem_read_data, 16'h0003);

        idle();
        alu_src         = 1'b1;
        imm             = 6'd9;
        reg_read_addr_2 = 3'd5;
        reg_write_dest  = 3'd5;
        reg_write_en    = 1'b1;
        #1;
        check("rw_same_old", reg_read_data_2, 16'h0005);
        step();
        check("rw_same_new", reg_read_data_2, 16'h0009);

        idle();
        reset          = 1'b1;
        alu_src        = 1'b1;
        imm            = 6'd7;
        reg_write_dest = 3'd5;
        reg_write_en   = 1'b1;
        mem_write      = 1'b1;
        step();
        read_reg("rst_wr_r5", 3'd5, 16'h0000);
        read_reg("rst_mid_r1", 3'd1, 16'h0000);
        idle();
        alu_src  = 1'b1;
        imm      = 6'd7;
        mem_read = 1'b1;
        #1;
        check("rst_mid_mem7", mem_read_data, 16'h0000);

        // Build 0x1234 = (0x12 << 8) | (0x1A << 1).
        load_imm(3'd1, 6'd18);
        idle();
        reg_read_addr_1 = 3'd1;
        alu_src         = 1'b1;
        alu_control     = 4'b0011;
        imm             = 6'd8;
        reg_write_dest  = 3'd1;
        reg_write_en    = 1'b1;
        step();
        load_imm(3'd2, 6'd26);
        idle();
        reg_read_addr_1 = 3'd2;
        alu_src         = 1'b1;
        alu_control     = 4'b0011;
        imm             = 6'd1;
        reg_write_dest  = 3'd2;
        reg_write_en    = 1'b1;
        step();
        read_reg("r1_1200", 3'd1, 16'h1200);
        read_reg("r2_0034", 3'd2, 16'h0034);

        idle();
        reg_read_addr_1 = 3'd1;
        reg_read_addr_2 = 3'd2;
        alu_control     = 4'b0101;
        #1;
        check("and_r1r2", alu_result, 16'h0000);
        alu_control = 4'b1111;
        #1;
        check("dflt_add", alu_result, 16'h1234);
        alu_control = 4'b0010;
        #1;
        check("inv_1200", alu_result, 16'hEDFF);
        alu_control    = 4'b0110;
        reg_write_dest = 3'd0;
        reg_write_en   = 1'b1;
        #1;
        check("or_r1r2", alu_result, 16'h1234);
        step();
`ifdef GPR_R0_ZERO_EN
        read_reg("r0_hardwired", 3'd0, 16'h0000);
`else
        read_reg("r0_writable", 3'd0, 16'h1234);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
